// File: rtl/dot_pkg.sv
// Shared types and constants for the dot-product accumulator.
// Optional feature macro: SATURATE_EN (clamp adds instead of wrapping).
package dot_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 8;

  localparam logic [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;
endpackage

// File: rtl/dot_accumulator_if.sv
// Stream bundle: partial sums in, finished dot products out.
// Handshake: in_* is a push (no ready; accepted whenever in_valid=1); out_* transfers
// on a clock edge where out_valid=1 and out_ready=1, and out_sum/out_count/out_sat
// stay stable while out_valid=1 and out_ready=0.
interface dot_accumulator_if
  import dot_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  out_valid, out_sum, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output out_valid, out_sum, out_count, out_sat
  );
endinterface

// File: rtl/sat_adder.sv
// Combinational signed add; under SATURATE_EN it clamps on overflow and flags the clamp.
// Without SATURATE_EN the sum wraps and ovf is constant 0.
module sat_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W-1:0] raw;

  assign raw = a + b;

`ifdef SATURATE_EN
  localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic wrap_ovf;

  // Overflow only when both operands share a sign and the result flips it.
  assign wrap_ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
  assign ovf      = wrap_ovf;

  always_comb begin
    sum = raw;
    if (wrap_ovf) sum = a[W-1] ? MIN : MAX;
  end
`else
  assign sum = raw;
  assign ovf = 1'b0;
`endif
endmodule

// File: rtl/dot_accumulator.sv
// Accumulates runs of partial sums (closed by in_last) into a held, handshaked result.
// Optional feature macro: SATURATE_EN (clamping adds, out_sat reports a clamp in the run).
module dot_accumulator
  import dot_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  dot_accumulator_if.slave         bus,
  output logic                     busy,
  output logic                     err_drop,
  output state_t                   dbg_state
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              run_sat;

  logic              out_valid;
  logic [DATA_W-1:0] out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;

  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] sum;
  logic              ovf;
  logic [CNT_W-1:0]  cnt_next;
  logic              done;

  // A fresh run starts from zero, so the first term never clamps.
  assign base     = (state == ACCUM) ? acc : '0;
  assign cnt_next = (state != ACCUM) ? CNT_W'(1) :
                    (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign done     = bus.in_valid && bus.in_last;

  sat_adder #(.W(DATA_W)) u_add (
    .a   (base),
    .b   (bus.in_data),
    .sum (sum),
    .ovf (ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      run_sat   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      if (out_valid && bus.out_ready) out_valid <= 1'b0;

      if (done) begin
        // A result still waiting on the consumer wins; the new one is lost.
        if (out_valid && !bus.out_ready) begin
          err_drop <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_sum   <= sum;
          out_count <= cnt_next;
          out_sat   <= run_sat | ovf;
        end
        acc     <= '0;
        cnt     <= '0;
        run_sat <= 1'b0;
        state   <= IDLE;
      end else if (bus.in_valid) begin
        acc     <= sum;
        cnt     <= cnt_next;
        run_sat <= run_sat | ovf;
        state   <= ACCUM;
      end
    end
  end

  assign busy          = (state == ACCUM);
  assign dbg_state     = state;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_count = out_count;
  assign bus.out_sat   = out_sat;
endmodule
